// File: rtl/router_reg_pkg.sv
// router_reg_pkg: default widths, header layout and check helpers for router_reg_param
package router_reg_pkg;
    localparam int DATA_W_D = 8;
    localparam int ADDR_W_D = 2;
    typedef struct packed {
        logic [DATA_W_D-ADDR_W_D-1:0] len;
        logic [ADDR_W_D-1:0]          addr;
    } hdr_t;
    function automatic logic addr_ok(input int unsigned addr, input int unsigned num_ch);
        return addr < num_ch;
    endfunction
    function automatic logic [31:0] par_xor(input logic [31:0] acc, input logic [31:0] b);
        return acc ^ b;
    endfunction
endpackage

// File: rtl/router_reg_if.sv
// router_reg_if: FSM strobes, source byte and FIFO write bus of the router register stage
interface router_reg_if #(parameter int DATA_W = 8);
    logic              pkt_valid, fifo_full, detect_add, lfd_state, ld_state, laf_state, rst_int_reg;
    logic [DATA_W-1:0] data_in, dout;
    logic              dout_valid, parity_done, low_pkt_valid, err, len_err, addr_err, hold_empty, hold_ovf;
    logic [15:0]       pkt_cnt, err_cnt;
    modport master (
        output pkt_valid, fifo_full, detect_add, lfd_state, ld_state, laf_state, rst_int_reg, data_in,
        input  dout, dout_valid, parity_done, low_pkt_valid, err, len_err, addr_err, hold_empty, hold_ovf,
        input  pkt_cnt, err_cnt
    );
    modport slave (
        input  pkt_valid, fifo_full, detect_add, lfd_state, ld_state, laf_state, rst_int_reg, data_in,
        output dout, dout_valid, parity_done, low_pkt_valid, err, len_err, addr_err, hold_empty, hold_ovf,
        output pkt_cnt, err_cnt
    );
endinterface

// File: rtl/router_reg_param_hold_buf.sv
// router_hold_buf: HOLD_DEPTH x DATA_W circular FIFO with push/pop/flush; push wins over pop
module router_hold_buf #(
    parameter int DATA_W     = 8,
    parameter int HOLD_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int PW = HOLD_DEPTH > 1 ? $clog2(HOLD_DEPTH) : 1;
    localparam int CW = $clog2(HOLD_DEPTH + 1);
    logic [DATA_W-1:0] mem [HOLD_DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     cnt;
    logic              do_push, do_pop;
    assign full    = cnt == CW'(HOLD_DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;
    assign dout    = mem[rp];
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp == PW'(HOLD_DEPTH - 1) ? '0 : wp + PW'(1);
            if (do_pop) rp <= rp == PW'(HOLD_DEPTH - 1) ? '0 : rp + PW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/router_reg_param.sv
// router_reg_param: router header/payload register stage with parity, length/address checks, full-hold buffer; ROUTER_REG_STATS_EN adds packet/error counters
module router_reg_param
    import router_reg_pkg::*;
#(
    parameter int DATA_W     = DATA_W_D,
    parameter int ADDR_W     = ADDR_W_D,
    parameter int NUM_CH     = 3,
    parameter int HOLD_DEPTH = 2
) (
    input logic         clk,
    input logic         rst,
    router_reg_if.slave bus
);
    localparam int LEN_W = DATA_W - ADDR_W;
    logic [DATA_W-1:0] header, parity, pkt_parity, dout, hold_dout;
    logic [LEN_W-1:0]  pay_cnt;
    logic              dout_valid, parity_done, pd_q, low_pkt_valid, err, len_err, addr_err, hold_ovf;
    logic              hdr_in, hdr_ok, sel_lfd, sel_ld, sel_laf, push, pop, hold_full, hold_empty, chk;
    assign hdr_in  = bus.detect_add && bus.pkt_valid;
    assign hdr_ok  = hdr_in && addr_ok(32'(bus.data_in[ADDR_W-1:0]), NUM_CH);
    assign sel_lfd = !bus.detect_add && bus.lfd_state;
    assign sel_ld  = !bus.detect_add && !bus.lfd_state && bus.ld_state;
    assign sel_laf = !bus.detect_add && !bus.lfd_state && !bus.ld_state && bus.laf_state;
    assign push    = sel_ld && bus.fifo_full;
    assign pop     = sel_laf && !bus.fifo_full && !hold_empty;
    assign chk     = parity_done && !pd_q;
    router_hold_buf #(.DATA_W(DATA_W), .HOLD_DEPTH(HOLD_DEPTH)) u_hold (
        .clk(clk), .rst(rst), .flush(hdr_ok), .push(push), .pop(pop),
        .din(bus.data_in), .dout(hold_dout), .full(hold_full), .empty(hold_empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            header        <= '0;
            parity        <= '0;
            pkt_parity    <= '0;
            pay_cnt       <= '0;
            dout          <= '0;
            dout_valid    <= 1'b0;
            parity_done   <= 1'b0;
            pd_q          <= 1'b0;
            low_pkt_valid <= 1'b0;
            err           <= 1'b0;
            len_err       <= 1'b0;
            addr_err      <= 1'b0;
            hold_ovf      <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            pd_q       <= parity_done;
            if (chk) begin
                err     <= parity != pkt_parity;
                len_err <= pay_cnt != header[DATA_W-1:ADDR_W];
            end
            if (bus.rst_int_reg) low_pkt_valid <= 1'b0;
            if (hdr_ok) begin
                header      <= bus.data_in;
                parity      <= '0;
                pkt_parity  <= '0;
                pay_cnt     <= '0;
                parity_done <= 1'b0;
                err         <= 1'b0;
                len_err     <= 1'b0;
                hold_ovf    <= 1'b0;
                addr_err    <= 1'b0;
            end else if (hdr_in) begin
                addr_err <= 1'b1;
            end else if (sel_lfd) begin
                dout       <= header;
                dout_valid <= 1'b1;
                parity     <= DATA_W'(par_xor(32'(parity), 32'(header)));
            end else if (sel_ld) begin
                if (!bus.fifo_full) begin
                    dout       <= bus.data_in;
                    dout_valid <= 1'b1;
                end else if (hold_full) begin
                    hold_ovf <= 1'b1;
                end
                if (bus.pkt_valid) begin
                    parity  <= DATA_W'(par_xor(32'(parity), 32'(bus.data_in)));
                    pay_cnt <= &pay_cnt ? pay_cnt : pay_cnt + LEN_W'(1);
                end else begin
                    pkt_parity    <= bus.data_in;
                    parity_done   <= 1'b1;
                    low_pkt_valid <= 1'b1;
                end
            end else if (pop) begin
                dout       <= hold_dout;
                dout_valid <= 1'b1;
            end
        end
    end
    assign bus.dout          = dout;
    assign bus.dout_valid    = dout_valid;
    assign bus.parity_done   = parity_done;
    assign bus.low_pkt_valid = low_pkt_valid;
    assign bus.err           = err;
    assign bus.len_err       = len_err;
    assign bus.addr_err      = addr_err;
    assign bus.hold_empty    = hold_empty;
    assign bus.hold_ovf      = hold_ovf;
`ifdef ROUTER_REG_STATS_EN
    logic [15:0] pkt_cnt, err_cnt;
    logic        bad;
    assign bad = parity != pkt_parity || pay_cnt != header[DATA_W-1:ADDR_W] || hold_ovf;
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else if (chk) begin
            pkt_cnt <= pkt_cnt + 16'd1;
            err_cnt <= err_cnt + 16'(bad);
        end
    end
    assign bus.pkt_cnt = pkt_cnt;
    assign bus.err_cnt = err_cnt;
`else
    assign bus.pkt_cnt = '0;
    assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_router_reg_param.sv
// tb_router_reg_param: scoreboard bench with a queue-based packet model of the router register stage
module tb_router_reg_param;
    import router_reg_pkg::*;
    localparam int HOLD = 2;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    router_reg_if bus ();
    router_reg_param dut (.clk(clk), .rst(rst), .bus(bus));
    int         checks = 0, failures = 0, pkts = 0, bads = 0;
    logic [7:0] exp_q[$];
    logic [7:0] hold_q[$];
    logic [7:0] pl[$];
    logic [7:0] mon_e, cur_hdr, last_b;
    logic       exp_addr_err, ovf;
    always @(negedge clk) begin
        if (bus.dout_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL dout_unexpected act=%0h req=none", bus.dout);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.dout !== mon_e) begin
                    failures++;
                    $display("FAIL dout_seq act=%0h req=%0h", bus.dout, mon_e);
                end
            end
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.pkt_valid = 0; bus.data_in = 0; bus.fifo_full = 0; bus.detect_add = 0;
        bus.lfd_state = 0; bus.ld_state = 0; bus.laf_state = 0; bus.rst_int_reg = 0;
    endtask
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%0h req=%0h", n, a, e);
        end
    endtask
    task automatic chk_stats();
`ifdef ROUTER_REG_STATS_EN
        chk("pkt_cnt", bus.pkt_cnt, pkts);
        chk("err_cnt", bus.err_cnt, bads);
`else
        chk("stats_off", {bus.pkt_cnt, bus.err_cnt}, 0);
`endif
    endtask
    task automatic chk_reset();
        chk("reset_outs", {bus.dout, bus.dout_valid, bus.parity_done, bus.low_pkt_valid, bus.err,
                           bus.len_err, bus.addr_err, bus.hold_ovf, bus.hold_empty}, 32'h1);
        chk_stats();
    endtask
    task automatic header(input logic [7:0] h);
        idle(); bus.detect_add = 1; bus.pkt_valid = 1; bus.data_in = h;
        cyc();
        if (h[1:0] < 2'd3) begin
            cur_hdr = h;
            hold_q.delete();
            exp_addr_err = 0;
        end else exp_addr_err = 1;
        chk("addr_err", bus.addr_err, exp_addr_err);
        if (!exp_addr_err) begin
            chk("hdr_clears", {bus.err, bus.len_err, bus.hold_ovf, bus.parity_done, bus.hold_empty}, 32'h1);
        end
    endtask
    task automatic send_byte(input logic [7:0] b, input bit pv, input bit full);
        idle(); bus.ld_state = 1; bus.pkt_valid = pv; bus.data_in = b; bus.fifo_full = full;
        if (!full) begin
            exp_q.push_back(b);
            last_b = b;
        end else if (hold_q.size() < HOLD) hold_q.push_back(b);
        else ovf = 1;
        cyc();
    endtask
    task automatic packet(input logic [7:0] h, input logic [7:0] delta, input int fmask);
        logic [7:0] p;
        bit e_err, e_len;
        header(h);
        ovf = 0;
        idle(); bus.lfd_state = 1; exp_q.push_back(cur_hdr); last_b = cur_hdr;
        cyc();
        p = cur_hdr;
        foreach (pl[i]) begin
            p ^= pl[i];
            send_byte(pl[i], 1, fmask[i]);
        end
        send_byte(p ^ delta, 0, fmask[pl.size()]);
        chk("parity_done", bus.parity_done, 1);
        chk("low_pkt_valid", bus.low_pkt_valid, 1);
        idle(); cyc();
        e_err = delta != 0;
        e_len = pl.size() != int'(cur_hdr[7:2]);
        chk("err", bus.err, e_err);
        chk("len_err", bus.len_err, e_len);
        chk("hold_ovf", bus.hold_ovf, ovf);
        chk("hold_empty_pre", bus.hold_empty, hold_q.size() == 0);
        chk("dout_hold", bus.dout, last_b);
        pkts++;
        if (e_err || e_len || ovf) bads++;
        while (hold_q.size() > 0) begin
            idle(); bus.laf_state = 1; last_b = hold_q.pop_front(); exp_q.push_back(last_b);
            cyc();
        end
        chk("hold_empty_post", bus.hold_empty, 1);
        idle(); bus.rst_int_reg = 1;
        cyc();
        chk("low_pkt_clr", bus.low_pkt_valid, 0);
        chk("err_sticky", bus.err, e_err);
        chk("exp_drained", exp_q.size(), 0);
        chk_stats();
    endtask
    initial begin
        hdr_t hh;
        int   n;
        idle(); rst = 1; cur_hdr = 0; last_b = 0;
        cyc(); cyc();
        rst = 0;
        chk_reset();
        pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
        packet(8'h0D, 8'h00, 0);
        packet(8'h0D, 8'hF3, 0);
        header(8'h03);
        idle(); bus.lfd_state = 1; exp_q.push_back(cur_hdr);
        cyc();
        chk("addr_err_held", bus.addr_err, 1);
        pl.delete(); pl.push_back(8'h5A);
        packet(8'h05, 8'h00, 0);
        pl.delete(); pl.push_back(8'hAA); pl.push_back(8'hBB);
        packet(8'h09, 8'h00, 3);
        pl.delete(); pl.push_back(8'h01); pl.push_back(8'h02); pl.push_back(8'h03);
        packet(8'h0A, 8'h00, 7);
        for (int k = 0; k < 10; k++) begin
            hh.len  = 6'($urandom_range(0, 4));
            hh.addr = 2'($urandom_range(0, 2));
            n = int'(hh.len) + ($urandom_range(0, 3) == 0 ? 1 : 0);
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            packet(hh, $urandom_range(0, 3) == 0 ? 8'($urandom_range(1, 255)) : 8'h00,
                   $urandom_range(0, 1) ? int'($urandom_range(0, 63)) : 0);
        end
        header(8'h0D);
        idle(); bus.lfd_state = 1; exp_q.push_back(cur_hdr);
        cyc();
        send_byte(8'h11, 1, 0);
        idle(); bus.ld_state = 1; bus.pkt_valid = 1; bus.data_in = 8'h22; bus.fifo_full = 1; rst = 1;
        cyc();
        rst = 0; idle(); pkts = 0; bads = 0; hold_q.delete(); exp_addr_err = 0;
        chk_reset();
        chk("exp_drained_rst", exp_q.size(), 0);
        pl.delete(); pl.push_back(8'h44);
        packet(8'h06, 8'h00, 0);
        chk("exp_final", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
